vit_sync_ctrl_213: RTL and testbench
====================================

// Module: vit_sync_ctrl_213
// PURPOSE
//  Resynchronisation controller for the (2,1,3) Viterbi decoder. Watches the per-stage
//  out-of-sync error flag, decides loss of lock by error density per window, and steps the
//  front end through 4 hypotheses: symbol-pair phase (0/1) x symbol inversion (0/1).
//  On each step it flushes path metrics and holds off for settling. Sits between the
//  sync-error detector and the symbol deserialiser / path-metric unit.
// PARAMETERS
//  WIN        16  stages per error-counting window (>=2)
//  THRESH     4   errors within one window that declare loss of sync (1..WIN)
//  LOCK_WIN   2   consecutive clean windows needed to assert locked (>=1)
//  SETTLE_STG 8   stage strobes ignored after a flush (>=1)
//  FLUSH_LEN  3   clock cycles flush is held high (>=1)
// PORTS
//  clock      in   1  rising-edge clock
//  reset      in   1  synchronous, active-low reset
//  stage_en   in   1  one-cycle strobe per decoded stage; sync_err is valid only with it
//  sync_err   in   1  out-of-sync flag from the error detector
//  slip       out  1  one-cycle pulse: deserialiser shifts pairing by one symbol
//  invert     out  1  level: invert received symbols (= hyp[1])
//  flush      out  1  level: clear path metrics / survivor memory
//  locked     out  1  level: sync declared
//  lock_lost  out  1  one-cycle pulse: sync lost while locked
//  no_sync    out  1  sticky: all 4 hypotheses failed since last lock
//  hyp        out  2  current hypothesis {invert, phase}
//  err_cnt    out  ceil(log2(THRESH+1))  errors in current window (saturates at THRESH)
// BEHAVIOUR
//  Reset (reset==0 at clock edge): state=SETTLE, all counters 0, hyp=0, every output 0.
//   Takes priority over everything, in any state; the next edge after release runs SETTLE.
//  SETTLE: sync_err ignored; count stage_en; on SETTLE_STG-th strobe -> MONITOR with
//   window pos=0, err_cnt=0.
//  MONITOR, per stage_en: pos++; if sync_err, err_cnt++ (saturating).
//   - err_cnt reaching THRESH -> SLIP on next edge (same strobe as window end: SLIP wins).
//   - pos==WIN-1 with err_cnt<THRESH after update: clean window; pos,err_cnt<=0;
//     clean_cnt++ (saturating at LOCK_WIN); locked<=1 when clean_cnt hits LOCK_WIN,
//     no_sync<=0 and fail_cnt<=0 at the same edge.
//   - Window ending with a prior error count below THRESH does not clear clean_cnt;
//     only SLIP clears clean_cnt.
//   - No stage_en -> no state change.
//  SLIP (exactly 1 cycle): slip=1; hyp<=hyp+1 (wraps 3->0); invert follows new hyp[1];
//   lock_lost=1 iff locked was 1; locked<=0; clean_cnt<=0; fail_cnt++ (2 bits, wraps);
//   if fail_cnt was 3, set no_sync. Next -> FLUSH.
//  FLUSH: flush=1 for exactly FLUSH_LEN cycles (stage_en ignored), then SETTLE.
//  Latency: threshold-hitting strobe at edge N -> slip=1 during cycle N+1,
//   flush=1 cycles N+2..N+1+FLUSH_LEN.
//  slip, lock_lost: never high 2 consecutive cycles.
//  err_cnt: visible on the cycle after the strobe that updates it.
//  All outputs registered; no combinational input->output path.
// TESTING
//  1 Reset then 8 strobes no err, 32 strobes no err -> locked=1 after 2nd window end;
//    slip, flush never high.
//  2 From locked, 4 sync_err in one 16-stage window -> slip and lock_lost pulse once;
//    hyp 0->1; flush high 3 cycles; locked=0.
//  3 Continuous sync_err from reset -> hyp cycles 1,2,3,0; invert=1 for hyp 2,3;
//    no_sync set on 4th slip; a later clean lock clears it.
//  4 3 errors per window, never 4 -> no slip; locked after 2 windows;
//    4th error on the window's last strobe -> SLIP, not clean.
//  5 stage_en gapped (1 in 3 cycles) -> identical decisions to dense strobes;
//    sync_err without stage_en ignored.
//  6 Assert reset during FLUSH and during MONITOR with err_cnt=3 -> all outputs 0
//    next edge; hyp=0; restart in SETTLE.

Source files
------------

// File: rtl/vit_sync_ctrl_213.sv
// Resynchronisation controller for the (2,1,3) Viterbi decoder: tracks error density per
// window, declares lock, and steps phase/inversion hypotheses with flush and settling.
module vit_sync_ctrl_213 #(
    parameter int WIN        = 16,
    parameter int THRESH     = 4,
    parameter int LOCK_WIN   = 2,
    parameter int SETTLE_STG = 8,
    parameter int FLUSH_LEN  = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             stage_en,
    input  logic                             sync_err,
    output logic                             slip,
    output logic                             invert,
    output logic                             flush,
    output logic                             locked,
    output logic                             lock_lost,
    output logic                             no_sync,
    output logic [1:0]                       hyp,
    output logic [$clog2(THRESH+1)-1:0]      err_cnt
);

    localparam int EW = $clog2(THRESH + 1);
    localparam int CW = $clog2(LOCK_WIN + 1);
    localparam int PW = $clog2(WIN);
    localparam int SW = (SETTLE_STG > 1) ? $clog2(SETTLE_STG) : 1;
    localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    typedef enum logic [1:0] {
        ST_SETTLE  = 2'd0,
        ST_MONITOR = 2'd1,
        ST_SLIP    = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   settle_cnt_q;
    logic [PW-1:0]   pos_q;
    logic [EW-1:0]   err_cnt_q;
    logic [CW-1:0]   clean_cnt_q;
    logic [1:0]      fail_cnt_q;
    logic [FW-1:0]   flush_cnt_q;
    logic [1:0]      hyp_q;
    logic            slip_q;
    logic            lock_lost_q;
    logic            flush_q;
    logic            locked_q;
    logic            no_sync_q;

    logic [EW-1:0]   err_cnt_d;
    logic [CW-1:0]   clean_cnt_d;

    // Saturating candidate values for the error and clean-window counters.
    always_comb begin
        err_cnt_d   = err_cnt_q;
        clean_cnt_d = clean_cnt_q;
        if (sync_err && (err_cnt_q != EW'(THRESH))) begin
            err_cnt_d = err_cnt_q + EW'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
        if (clean_cnt_q != CW'(LOCK_WIN)) begin
            clean_cnt_d = clean_cnt_q + CW'(1);
        end else begin
            clean_cnt_d = clean_cnt_q;
        end
    end

    // Controller FSM with all outputs registered; slip actions happen on the edge entering SLIP.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            pos_q        <= '0;
            err_cnt_q    <= '0;
            clean_cnt_q  <= '0;
            fail_cnt_q   <= 2'd0;
            flush_cnt_q  <= '0;
            hyp_q        <= 2'd0;
            slip_q       <= 1'b0;
            lock_lost_q  <= 1'b0;
            flush_q      <= 1'b0;
            locked_q     <= 1'b0;
            no_sync_q    <= 1'b0;
        end else begin
            slip_q      <= 1'b0;
            lock_lost_q <= 1'b0;
            case (state_q)
                ST_SETTLE: begin
                    if (stage_en) begin
                        if (settle_cnt_q == SW'(SETTLE_STG - 1)) begin
                            state_q      <= ST_MONITOR;
                            settle_cnt_q <= '0;
                            pos_q        <= '0;
                            err_cnt_q    <= '0;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + SW'(1);
                        end
                    end
                end
                ST_MONITOR: begin
                    if (stage_en) begin
                        // Threshold takes precedence over a coincident window end.
                        if (err_cnt_d == EW'(THRESH)) begin
                            state_q     <= ST_SLIP;
                            err_cnt_q   <= err_cnt_d;
                            slip_q      <= 1'b1;
                            hyp_q       <= hyp_q + 2'd1;
                            lock_lost_q <= locked_q;
                            locked_q    <= 1'b0;
                            clean_cnt_q <= '0;
                            fail_cnt_q  <= fail_cnt_q + 2'd1;
                            if (fail_cnt_q == 2'd3) begin
                                no_sync_q <= 1'b1;
                            end
                        end else if (pos_q == PW'(WIN - 1)) begin
                            pos_q       <= '0;
                            err_cnt_q   <= '0;
                            clean_cnt_q <= clean_cnt_d;
                            if (clean_cnt_d == CW'(LOCK_WIN)) begin
                                locked_q   <= 1'b1;
                                no_sync_q  <= 1'b0;
                                fail_cnt_q <= 2'd0;
                            end
                        end else begin
                            pos_q     <= pos_q + PW'(1);
                            err_cnt_q <= err_cnt_d;
                        end
                    end
                end
                ST_SLIP: begin
                    state_q     <= ST_FLUSH;
                    flush_q     <= 1'b1;
                    flush_cnt_q <= '0;
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == FW'(FLUSH_LEN - 1)) begin
                        state_q     <= ST_SETTLE;
                        flush_q     <= 1'b0;
                        flush_cnt_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FW'(1);
                    end
                end
                default: begin
                    state_q <= ST_SETTLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign slip      = slip_q;
    assign invert    = hyp_q[1];
    assign flush     = flush_q;
    assign locked    = locked_q;
    assign lock_lost = lock_lost_q;
    assign no_sync   = no_sync_q;
    assign hyp       = hyp_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_vit_sync_ctrl_213.sv
// Directed self-checking bench for vit_sync_ctrl_213 with default parameters.
module tb_vit_sync_ctrl_213;

    logic       clock = 1'b0;
    logic       reset;
    logic       stage_en;
    logic       sync_err;
    logic       slip, invert, flush, locked, lock_lost, no_sync;
    logic [1:0] hyp;
    logic [2:0] err_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int slip_cnt = 0;
    int flush_cyc = 0;
    int ll_cnt = 0;
    int consec_bad = 0;
    logic slip_prev = 1'b0;
    logic ll_prev = 1'b0;

    vit_sync_ctrl_213 dut (
        .clock     (clock),
        .reset     (reset),
        .stage_en  (stage_en),
        .sync_err  (sync_err),
        .slip      (slip),
        .invert    (invert),
        .flush     (flush),
        .locked    (locked),
        .lock_lost (lock_lost),
        .no_sync   (no_sync),
        .hyp       (hyp),
        .err_cnt   (err_cnt)
    );

    always #5 clock = ~clock;

    // Pulse/level observers sampled mid-cycle.
    always @(negedge clock) begin
        slip_cnt  <= slip_cnt + int'(slip);
        flush_cyc <= flush_cyc + int'(flush);
        ll_cnt    <= ll_cnt + int'(lock_lost);
        if ((slip && slip_prev) || (lock_lost && ll_prev)) consec_bad <= consec_bad + 1;
        slip_prev <= slip;
        ll_prev   <= lock_lost;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {22'd0, slip, invert, flush, locked, lock_lost, no_sync, hyp, err_cnt}, 32'd0);
    endtask

    task automatic strobe(input logic e);
        stage_en = 1'b1;
        sync_err = e;
        @(posedge clock); #1;
        stage_en = 1'b0;
        sync_err = 1'b0;
    endtask

    task automatic idle(input int n, input logic e);
        sync_err = e;
        repeat (n) begin
            @(posedge clock); #1;
        end
        sync_err = 1'b0;
    endtask

    task automatic run(input logic [31:0] pat, input int n);
        for (int i = 0; i < n; i++) strobe(pat[i]);
    endtask

    task automatic grun(input logic [31:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            strobe(pat[i]);
            idle(2, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b0;
        stage_en = 1'b0;
        sync_err = 1'b0;
        idle(3, 1'b0);
        chk_zero("reset_outputs");
        reset = 1'b1;

        // Test 1: settle then two clean windows lock
        run(32'h0, 8);
        chk("t1_err_after_settle", err_cnt, 32'd0);
        run(32'h0, 31);
        chk("t1_not_locked_yet", locked, 32'd0);
        run(32'h0, 1);
        chk("t1_locked", locked, 32'd1);
        chk("t1_no_slip", slip_cnt, 32'd0);
        chk("t1_no_flush", flush_cyc, 32'd0);

        // Test 2: four errors in a window break lock
        run(32'h7, 3);
        chk("t2_err3", err_cnt, 32'd3);
        chk("t2_no_slip_at3", slip, 32'd0);
        run(32'h1, 1);
        chk("t2_slip", slip, 32'd1);
        chk("t2_lock_lost", lock_lost, 32'd1);
        chk("t2_hyp", hyp, 32'd1);
        chk("t2_unlocked", locked, 32'd0);
        idle(1, 1'b0);
        chk("t2_slip_drop", slip, 32'd0);
        chk("t2_flush_on", flush, 32'd1);
        idle(4, 1'b0);
        chk("t2_flush_off", flush, 32'd0);
        chk("t2_slip_cnt", slip_cnt, 32'd1);
        chk("t2_ll_cnt", ll_cnt, 32'd1);
        chk("t2_flush_cyc", flush_cyc, 32'd3);
        chk("t2_invert", invert, 32'd0);

        // Test 4: three errors per window never slip; fourth on last strobe does
        run(32'h0, 8);
        run(32'h0000_0421, 15);
        chk("t4_err3", err_cnt, 32'd3);
        run(32'h0, 1);
        chk("t4_win1_clear", err_cnt, 32'd0);
        chk("t4_win1_unlocked", locked, 32'd0);
        run(32'h0000_0421, 16);
        chk("t4_locked", locked, 32'd1);
        chk("t4_slip_cnt", slip_cnt, 32'd1);
        run(32'h7, 15);
        chk("t4_err3_w3", err_cnt, 32'd3);
        run(32'h1, 1);
        chk("t4_slip_lastpos", slip, 32'd1);
        chk("t4_unlocked", locked, 32'd0);
        chk("t4_hyp", hyp, 32'd2);
        chk("t4_invert", invert, 32'd1);
        chk("t4_lock_lost", lock_lost, 32'd1);
        idle(5, 1'b0);

        // Test 5: gapped strobes with stray sync_err between them
        grun(32'h0, 8);
        grun(32'h0, 31);
        chk("t5_not_locked_yet", locked, 32'd0);
        grun(32'h0, 1);
        chk("t5_locked", locked, 32'd1);
        chk("t5_slip_cnt", slip_cnt, 32'd2);
        grun(32'h7, 3);
        chk("t5_err3", err_cnt, 32'd3);
        strobe(1'b1);
        chk("t5_slip", slip, 32'd1);
        chk("t5_hyp", hyp, 32'd3);
        chk("t5_lock_lost", lock_lost, 32'd1);

        // Test 6a: reset during FLUSH
        idle(1, 1'b0);
        chk("t6_in_flush", flush, 32'd1);
        reset = 1'b0;
        idle(1, 1'b0);
        chk_zero("t6_reset_in_flush");
        idle(1, 1'b0);
        reset = 1'b1;
        chk("t6_flush_cyc", flush_cyc, 32'd7);
        chk("t6_ll_cnt", ll_cnt, 32'd3);

        // Test 3: continuous errors walk all four hypotheses
        for (int k = 0; k < 4; k++) begin
            run(32'hFFFF_FFFF, 11);
            chk("t3_err3", err_cnt, 32'd3);
            run(32'h1, 1);
            chk("t3_slip", slip, 32'd1);
            chk("t3_hyp", hyp, 32'(k + 1) & 32'd3);
            chk("t3_invert", invert, (k == 1 || k == 2) ? 32'd1 : 32'd0);
            chk("t3_no_sync", no_sync, (k == 3) ? 32'd1 : 32'd0);
            chk("t3_no_lock_lost", lock_lost, 32'd0);
            idle(4, 1'b1);
        end
        chk("t3_slip_cnt", slip_cnt, 32'd7);
        chk("t3_flush_cyc", flush_cyc, 32'd19);
        run(32'h0, 8);
        run(32'h0, 31);
        chk("t3_no_sync_held", no_sync, 32'd1);
        run(32'h0, 1);
        chk("t3_relock", locked, 32'd1);
        chk("t3_no_sync_clear", no_sync, 32'd0);

        // Test 6b: reset in MONITOR with err_cnt=3, then restart in SETTLE
        run(32'h7, 3);
        chk("t6b_err3", err_cnt, 32'd3);
        reset = 1'b0;
        idle(1, 1'b0);
        chk_zero("t6b_reset_in_monitor");
        reset = 1'b1;
        run(32'hFF, 8);
        chk("t6b_settle_ignores_err", err_cnt, 32'd0);
        run(32'h7, 3);
        chk("t6b_err3_again", err_cnt, 32'd3);
        chk("t6b_slip_cnt", slip_cnt, 32'd7);
        chk("t6b_ll_cnt", ll_cnt, 32'd3);
        chk("pulse_never_consecutive", consec_bad, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
